// File: rtl/sram_ctrl.sv
`timescale 1ns/1ps
// sram_ctrl: cycle-exact access sequencer for a small SRAM array (wordlines, write driver, read sampling).
// Latency: write WR_PULSE+RECOV cycles to done (plus RD_PULSE+RECOV with verify), read RD_PULSE+1 to rvalid.
// Backpressure: req_ready only in IDLE; nothing is queued while an operation is in flight.
//
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   req_valid/req_ready     - request handshake; req_we selects write(1)/read(0)
//   req_addr, req_wdata     - row index and write bit
//   row_wr, row_rd          - one-hot write/read wordlines (never high together)
//   data_in                 - real write-driver level (VDD or VSS)
//   preout                  - real sense-amplifier output, compared against VTH
//   rdata, rvalid           - read result and its one-cycle strobe
//   done, vfail             - end-of-operation strobe and write-verify mismatch
//
// Optional feature: define SRAM_CTRL_VERIFY_EN to read back every write (VREAD/VRECOV)
// and report a mismatch on vfail together with done. Undefined: vfail is tied to 0.

module sram_ctrl #(
  parameter int  NROWS    = 4,
  parameter int  WR_PULSE = 10,
  parameter int  RD_PULSE = 10,
  parameter int  RECOV    = 10,
  parameter real VDD      = 1.5,
  parameter real VSS      = 0.0,
  parameter real VTH      = 0.8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(NROWS)-1:0] req_addr,
  input  logic                     req_wdata,
  output logic [NROWS-1:0]         row_wr,
  output logic [NROWS-1:0]         row_rd,
  output real                      data_in,
  input  real                      preout,
  output logic                     rdata,
  output logic                     rvalid,
  output logic                     done,
  output logic                     vfail
);

  localparam int AW    = $clog2(NROWS);
  localparam int MAXP0 = (WR_PULSE > RD_PULSE) ? WR_PULSE : RD_PULSE;
  localparam int MAXP  = (MAXP0 > RECOV) ? MAXP0 : RECOV;
  localparam int CW    = $clog2(MAXP + 1);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WRITE    = 3'd1;
  localparam logic [2:0] WR_RECOV = 3'd2;
  localparam logic [2:0] READ     = 3'd3;
  localparam logic [2:0] RD_RECOV = 3'd4;
`ifdef SRAM_CTRL_VERIFY_EN
  localparam logic [2:0] VREAD    = 3'd5;
  localparam logic [2:0] VRECOV   = 3'd6;
`endif

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    addr_q;
  logic             last;
  logic [NROWS-1:0] wl;
  logic             rd_phase;
`ifdef SRAM_CTRL_VERIFY_EN
  logic             wdata_q;
  logic             vbad;
`endif

  // Every phase loads cnt with (length-1) on entry and leaves when it reaches 0.
  assign last      = (cnt == '0);
  assign req_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_in <= VSS;
      rdata   <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
      wdata_q <= 1'b0;
      vbad    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            if (req_we) begin
              state   <= WRITE;
              cnt     <= CW'(WR_PULSE - 1);
              data_in <= req_wdata ? VDD : VSS;
`ifdef SRAM_CTRL_VERIFY_EN
              wdata_q <= req_wdata;
`endif
            end else begin
              state <= READ;
              cnt   <= CW'(RD_PULSE - 1);
            end
          end
        end
        WRITE: begin
          if (last) begin
            state <= WR_RECOV;
            cnt   <= CW'(RECOV - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_RECOV: begin
          if (last) begin
`ifdef SRAM_CTRL_VERIFY_EN
            state <= VREAD;
            cnt   <= CW'(RD_PULSE - 1);
`else
            state <= IDLE;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READ: begin
          if (last) begin
            // Strictly greater: preout exactly at threshold reads as 0.
            rdata <= (preout > VTH);
            state <= RD_RECOV;
            cnt   <= CW'(RECOV - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_RECOV: begin
          if (last) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef SRAM_CTRL_VERIFY_EN
        VREAD: begin
          if (last) begin
            // Verify sample goes to vbad only; rdata keeps the last real read.
            vbad  <= ((preout > VTH) != wdata_q);
            state <= VRECOV;
            cnt   <= CW'(RECOV - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        VRECOV: begin
          if (last) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Row decode; an index at or beyond NROWS matches no bit, so no wordline fires.
  always_comb begin
    wl = '0;
    for (int i = 0; i < NROWS; i++) begin
      wl[i] = (int'(addr_q) == i);
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  assign rd_phase = (state == READ) || (state == VREAD);
`else
  assign rd_phase = (state == READ);
`endif

  // Wordlines decode straight from state so an async reset drops them at once.
  assign row_wr = (state == WRITE) ? wl : '0;
  assign row_rd = rd_phase ? wl : '0;

  assign rvalid = (state == RD_RECOV) && (cnt == CW'(RECOV - 1));

`ifdef SRAM_CTRL_VERIFY_EN
  assign done  = ((state == RD_RECOV) || (state == VRECOV)) && last;
  assign vfail = (state == VRECOV) && last && vbad;
`else
  assign done  = ((state == RD_RECOV) || (state == WR_RECOV)) && last;
  assign vfail = 1'b0;
`endif

endmodule
